// File: rtl/alu_flop_if.sv
// Bus bundle between the multicycle controller/datapath and alu_flop_unit.
// The master drives operands, operation select and enable-register data;
// the slave (alu_flop_unit) returns the ALU result, flags and both registers.
interface alu_flop_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] aluresult;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] aluout;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (
    output srca, srcb, alucontrol, en, d,
    input  aluresult, zero, overflow, aluout, q
  );

  modport slave (
    input  srca, srcb, alucontrol, en, d,
    output aluresult, zero, overflow, aluout, q
  );
endinterface

// File: rtl/alu_flop_unit.sv
// ALU core of the multicycle MIPS datapath plus its two register primitives:
// a free-running ALUOut register and a load-enable (PC/EPC/IR style) register.
// ALU outputs are purely combinational and ignore reset.
module alu_flop_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu_flop_if.slave   alu_if
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_RSV  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] sum;      // a + b
  logic [WIDTH-1:0] diff;     // a - b
  logic             a_msb, b_msb;
  logic             ovf_add, ovf_sub;
  logic             slt_bit;
  logic [WIDTH-1:0] result;
  logic             ovf;

  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] q_q, q_d;

  assign a     = alu_if.srca;
  assign b     = alu_if.srcb;
  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign sum   = a + b;
  assign diff  = a - b;

  // Signed overflow: ADD with like-signed operands flipping sign,
  // SUB with unlike-signed operands whose result sign departs from a.
  assign ovf_add = (a_msb == b_msb) && (sum[WIDTH-1]  != a_msb);
  assign ovf_sub = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);

  // Exact signed less-than: when signs differ the negative operand is smaller,
  // otherwise a - b cannot overflow and its sign bit is the answer.
  assign slt_bit = (a_msb != b_msb) ? a_msb : diff[WIDTH-1];

  // Operation select; reserved code yields zero so the zero flag reads 1.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (alu_if.alucontrol)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  begin result = sum;  ovf = ovf_add; end
      OP_SUB:  begin result = diff; ovf = ovf_sub; end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_ANDN: result = a & ~b;
      OP_ORN:  result = a | ~b;
      OP_RSV:  result = '0;
      default: result = '0;
    endcase
  end

  assign alu_if.aluresult = result;
  assign alu_if.zero      = (result == '0);
  assign alu_if.overflow  = ovf;

  // Next-state values for both registers; reset is applied in the flop block.
  always_comb begin
    aluout_d = result;
    q_d      = q_q;
    if (alu_if.en) q_d = alu_if.d;
  end

  // ALUOut captures every edge; enable register loads only when en is high.
  // Reset wins over en.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluout_q <= '0;
      q_q      <= '0;
    end else begin
      aluout_q <= aluout_d;
      q_q      <= q_d;
    end
  end

  assign alu_if.aluout = aluout_q;
  assign alu_if.q      = q_q;

endmodule

// File: tb/tb_alu_flop_unit.sv
// Bench for alu_flop_unit: directed vector table for the ALU, hand sequences
// for the registers, then randomized cycles against an arithmetic model.
module tb_alu_flop_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_flop_if #(.WIDTH(W)) bus ();

  alu_flop_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .alu_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zr;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: signed values widened to 64 bits, plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ov);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full = 0;
    r  = 32'h0;
    ov = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin full = sa + sb; r = full[31:0];
              ov = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      3'd6: begin full = sa - sb; r = full[31:0];
              ov = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: r = a & ~b;
      3'd5: r = a | ~b;
      default: r = 32'h0;
    endcase
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.alucontrol = op;
    bus.srca = a;
    bus.srcb = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[12];

  initial begin
    logic [31:0] er, exp_aluout, exp_q;
    logic        eo;

    vt[0]  = '{3'b010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
    vt[1]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vt[2]  = '{3'b110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};
    vt[3]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vt[4]  = '{3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0};
    vt[5]  = '{3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b0};
    vt[6]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vt[7]  = '{3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vt[8]  = '{3'b111, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1, 1'b0};
    vt[9]  = '{3'b011, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
    vt[10] = '{3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF000_00F0, 1'b0, 1'b0};
    vt[11] = '{3'b101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hF0FF_F0FF, 1'b0, 1'b0};

    // Reset state
    reset = 1'b1;
    bus.en = 1'b0;
    bus.d  = 32'h0;
    drive(3'b010, 32'h2, 32'h3);
    tick();
    chk("reset_aluout", bus.aluout, 32'h0);
    chk("reset_q", bus.q, 32'h0);
    #1;
    chk("comb_during_reset", bus.aluresult, 32'h5);

    // Directed ALU table
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b);
      #1;
      chk($sformatf("vec%0d_res", i), bus.aluresult, vt[i].res);
      chk($sformatf("vec%0d_zero", i), {31'h0, bus.zero}, {31'h0, vt[i].zr});
      chk($sformatf("vec%0d_ovf", i), {31'h0, bus.overflow}, {31'h0, vt[i].ov});
    end

    // Result register: ADD 2+3 then SUB 9-4, then reset
    @(negedge clk);
    drive(3'b010, 32'd2, 32'd3);
    tick();
    chk("aluout_add", bus.aluout, 32'h5);
    @(negedge clk);
    drive(3'b110, 32'd9, 32'd4);
    tick();
    chk("aluout_sub", bus.aluout, 32'h5);
    @(negedge clk);
    drive(3'b001, 32'hAAAA_0000, 32'h0000_5555);
    reset = 1'b1;
    tick();
    chk("aluout_reset", bus.aluout, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("aluout_after_release", bus.aluout, 32'hAAAA_5555);

    // Enable register
    @(negedge clk);
    bus.en = 1'b1;
    bus.d  = 32'h1234_5678;
    tick();
    chk("q_load", bus.q, 32'h1234_5678);
    @(negedge clk);
    bus.en = 1'b0;
    bus.d  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("q_hold%0d", i), bus.q, 32'h1234_5678);
    end
    @(negedge clk);
    bus.en = 1'b1;
    reset  = 1'b1;
    tick();
    chk("q_reset_over_en", bus.q, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.d = 32'hCAFE_F00D;
    tick();
    chk("q_first_after_release", bus.q, 32'hCAFE_F00D);

    // Randomized cycles against the model
    exp_q = 32'hCAFE_F00D;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(3'($urandom_range(0, 7)), pick(), pick());
      bus.en = 1'($urandom_range(0, 1));
      bus.d  = $urandom;
      reset  = ($urandom_range(0, 15) == 0);
      #1;
      model(bus.alucontrol, bus.srca, bus.srcb, er, eo);
      chk("rnd_res", bus.aluresult, er);
      chk("rnd_zero", {31'h0, bus.zero}, {31'h0, (er == 32'h0)});
      chk("rnd_ovf", {31'h0, bus.overflow}, {31'h0, eo});
      exp_aluout = reset ? 32'h0 : er;
      if (reset) exp_q = 32'h0;
      else if (bus.en) exp_q = bus.d;
      tick();
      chk("rnd_aluout", bus.aluout, exp_aluout);
      chk("rnd_q", bus.q, exp_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
